branch_resolve_ctrl: RTL and testbench

- Controls the ID-stage branch comparator of the 5-stage MIPS pipeline for beq and bne.
- Detects RAW hazards on the comparator operands and stalls the front end the required number of cycles.
- Drives the comparator-operand forwarding muxes.
- Issues the PC redirect and the IF/ID flush when the branch resolves taken.

---
 rtl/branch_resolve_ctrl.sv | 141 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution control for beq/bne: RAW-hazard stalls, comparator forwarding, PC redirect.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_is_beq,
    input  logic              id_is_bne,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              cmp_eq,
    output logic [1:0]        fwd_s_sel,
    output logic [1:0]        fwd_t_sel,
    output logic              stall,
    output logic              pc_src_br,
    output logic              flush_ifid,
    output logic              busy,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_stalls
);

    typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       br, taken, resolve, stall_c;
    logic       s_ex, s_mem, s_wb, t_ex, t_mem, t_wb;
    logic [1:0] need_s, need_t, need;
    logic [1:0] fwd_s, fwd_t;

    assign br    = id_is_beq | id_is_bne;
    assign taken = cmp_eq ^ id_is_bne;

    // Register 0 is hard-wired, so it can never match a producer stage.
    assign s_ex  = ex_regwrite  && (ex_rd  == id_rs) && (id_rs != '0);
    assign s_mem = mem_regwrite && (mem_rd == id_rs) && (id_rs != '0);
    assign s_wb  = wb_regwrite  && (wb_rd  == id_rs) && (id_rs != '0);
    assign t_ex  = ex_regwrite  && (ex_rd  == id_rt) && (id_rt != '0);
    assign t_mem = mem_regwrite && (mem_rd == id_rt) && (id_rt != '0);
    assign t_wb  = wb_regwrite  && (wb_rd  == id_rt) && (id_rt != '0);

    assign need_s = (s_ex && ex_memread) ? 2'd2 :
                    (s_ex || (s_mem && mem_memread)) ? 2'd1 : 2'd0;
    assign need_t = (t_ex && ex_memread) ? 2'd2 :
                    (t_ex || (t_mem && mem_memread)) ? 2'd1 : 2'd0;
    assign need   = (need_s > need_t) ? need_s : need_t;

    assign fwd_s = (s_mem && !mem_memread) ? 2'b01 : s_wb ? 2'b10 : 2'b00;
    assign fwd_t = (t_mem && !mem_memread) ? 2'b01 : t_wb ? 2'b10 : 2'b00;

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        resolve = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (br) begin
                    if (need == 2'd0) begin
                        resolve = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = need - 2'd1;
                        state_d = (need == 2'd1) ? RESOLVE : STALL;
                    end
                end
            end
            STALL: begin
                if (!br) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                resolve = br;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall      = stall_c & ~rst;
    assign pc_src_br  = resolve & taken & ~rst;
    assign flush_ifid = resolve & taken & ~rst;
    assign busy       = (state_q != IDLE) & ~rst;
    assign fwd_s_sel  = (br && !rst) ? fwd_s : 2'b00;
    assign fwd_t_sel  = (br && !rst) ? fwd_t : 2'b00;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] br_cnt_q, tk_cnt_q, st_cnt_q;

    // Saturating counters: they stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            if (resolve && br_cnt_q != '1)          br_cnt_q <= br_cnt_q + 1'b1;
            if (resolve && taken && tk_cnt_q != '1) tk_cnt_q <= tk_cnt_q + 1'b1;
            if (stall_c && st_cnt_q != '1)          st_cnt_q <= st_cnt_q + 1'b1;
        end
    end

    assign stat_branches = rst ? '0 : br_cnt_q;
    assign stat_taken    = rst ? '0 : tk_cnt_q;
    assign stat_stalls   = rst ? '0 : st_cnt_q;
`else
    assign stat_branches = '0;
    assign stat_taken    = '0;
    assign stat_stalls   = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios then randomized cycles
// compared against a stall-countdown reference model.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_is_beq, id_is_bne;
    logic [4:0]  id_rs, id_rt;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_regwrite, mem_memread;
    logic [4:0]  mem_rd;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic        cmp_eq;
    logic [1:0]  fwd_s_sel, fwd_t_sel;
    logic        stall, pc_src_br, flush_ifid, busy;
    logic [31:0] stat_branches, stat_taken, stat_stalls;

    branch_resolve_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_is_beq     (id_is_beq),
        .id_is_bne     (id_is_bne),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread),
        .ex_rd         (ex_rd),
        .mem_regwrite  (mem_regwrite),
        .mem_memread   (mem_memread),
        .mem_rd        (mem_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .cmp_eq        (cmp_eq),
        .fwd_s_sel     (fwd_s_sel),
        .fwd_t_sel     (fwd_t_sel),
        .stall         (stall),
        .pc_src_br     (pc_src_br),
        .flush_ifid    (flush_ifid),
        .busy          (busy),
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken),
        .stat_stalls   (stat_stalls)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a branch in flight plus the stall cycles it still owes.
    bit          m_pend  = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_br    = '0;
    logic [31:0] m_tk    = '0;
    logic [31:0] m_st    = '0;
    int          n_stall_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hit(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return (we && rd == r && r != 5'd0) ? 1 : 0;
    endfunction

    function automatic int need_of(input logic [4:0] r);
        int n = 0;
        if (hit(ex_regwrite, ex_rd, r) != 0) n = ex_memread ? 2 : 1;
        else if (hit(mem_regwrite, mem_rd, r) != 0 && mem_memread) n = 1;
        return n;
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] r);
        if (hit(mem_regwrite, mem_rd, r) != 0 && !mem_memread) return 2'b01;
        if (hit(wb_regwrite, wb_rd, r) != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic step(input logic r, input logic beq, input logic bne,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic exw, input logic exm, input logic [4:0] exd,
                        input logic mw, input logic mm, input logic [4:0] md,
                        input logic ww, input logic [4:0] wd, input logic eq);
        logic       br, tk, e_stall, e_pc, e_busy, res;
        logic [1:0] e_fs, e_ft;
        int         need;
        bit         n_pend;
        int         n_left;
        logic [31:0] e_sb, e_stk, e_sst;

        @(negedge clk);
        rst = r; id_is_beq = beq; id_is_bne = bne; id_rs = rs; id_rt = rt;
        ex_regwrite = exw; ex_memread = exm; ex_rd = exd;
        mem_regwrite = mw; mem_memread = mm; mem_rd = md;
        wb_regwrite = ww; wb_rd = wd; cmp_eq = eq;
        #1;

        br = beq | bne;
        tk = eq ^ bne;
        need = need_of(rs) > need_of(rt) ? need_of(rs) : need_of(rt);
        e_stall = 0; e_pc = 0; e_busy = 0; res = 0;
        e_fs = 2'b00; e_ft = 2'b00;
        n_pend = m_pend; n_left = m_left;
        e_sb = 0; e_stk = 0; e_sst = 0;

        if (!r) begin
            if (br) begin
                e_fs = fwd_of(rs);
                e_ft = fwd_of(rt);
            end
            e_busy = m_pend;
            if (!m_pend) begin
                if (br && need == 0) res = 1;
                else if (br) begin
                    e_stall = 1; n_pend = 1; n_left = need - 1;
                end
            end else if (!br) begin
                n_pend = 0;
            end else if (m_left > 0) begin
                e_stall = 1; n_left = m_left - 1;
            end else begin
                res = 1; n_pend = 0;
            end
            e_pc = res & tk;
`ifdef BRANCH_STATS_EN
            e_sb = m_br; e_stk = m_tk; e_sst = m_st;
`endif
        end else begin
            n_pend = 0; n_left = 0;
        end

        check("stall",      stall,         e_stall);
        check("pc_src_br",  pc_src_br,     e_pc);
        check("flush_ifid", flush_ifid,    e_pc);
        check("busy",       busy,          e_busy);
        check("fwd_s_sel",  fwd_s_sel,     e_fs);
        check("fwd_t_sel",  fwd_t_sel,     e_ft);
        check("stat_br",    stat_branches, e_sb);
        check("stat_taken", stat_taken,    e_stk);
        check("stat_stall", stat_stalls,   e_sst);
        if (stall) n_stall_seen++;

        @(posedge clk);
        m_pend = n_pend; m_left = n_left;
        if (r) begin
            m_br = 0; m_tk = 0; m_st = 0;
        end else begin
            if (res) m_br = sat_inc(m_br);
            if (res && tk) m_tk = sat_inc(m_tk);
            if (e_stall) m_st = sat_inc(m_st);
        end
    endtask

    task automatic idle_cycle(input logic r);
        step(r, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_cycle(1);
        idle_cycle(1);
        idle_cycle(0);

        // Hazard-free beq, taken in the same cycle.
        step(0, 1, 0, 5'd4, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 1);

        // Load-use on rs: two stall cycles, then RESOLVE forwarding from WB, not taken.
        n_stall_seen = 0;
        step(0, 1, 0, 5'd8, 5'd5, 1, 1, 5'd8, 0, 0, 5'd0, 0, 5'd0, 0);
        step(0, 1, 0, 5'd8, 5'd5, 0, 0, 5'd0, 1, 1, 5'd8, 0, 5'd0, 0);
        step(0, 1, 0, 5'd8, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd8, 0);
        check("load_stall_count", n_stall_seen, 2);

        // ALU producer on rt for bne: one stall, then forward from EX/MEM, taken.
        n_stall_seen = 0;
        step(0, 0, 1, 5'd3, 5'd9, 1, 0, 5'd9, 0, 0, 5'd0, 0, 5'd0, 0);
        step(0, 0, 1, 5'd3, 5'd9, 0, 0, 5'd0, 1, 0, 5'd9, 0, 5'd0, 0);
        check("alu_stall_count", n_stall_seen, 1);

        // Register 0 never stalls or forwards; bne with equal operands is not taken.
        step(0, 1, 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 5'd0, 1, 5'd0, 1);
        step(0, 0, 1, 5'd6, 5'd7, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 1);

        // Reset during the first stall cycle, then a fresh branch.
        step(0, 1, 0, 5'd8, 5'd5, 1, 1, 5'd8, 0, 0, 5'd0, 0, 5'd0, 0);
        step(1, 1, 0, 5'd8, 5'd5, 1, 1, 5'd8, 1, 1, 5'd8, 1, 5'd8, 1);
        step(0, 1, 0, 5'd4, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 1);

        // Abort mid-STALL by dropping the branch.
        step(0, 0, 1, 5'd2, 5'd8, 1, 1, 5'd8, 0, 0, 5'd0, 0, 5'd0, 0);
        idle_cycle(0);
        idle_cycle(0);

        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            step(($urandom_range(0, 49) == 0),
                 (sel == 1 || sel == 3 || sel >= 6), (sel == 2 || sel == 4 || sel == 5),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
